multicast_fork_scheduler: RTL and testbench

- Sits between an input-port FIFO head and the five output-port arbiters of the lookahead router.
- Latches the multicast direction mask produced by lookahead routing on the head flit.
- Replicates every flit of the packet (head..tail, wormhole) to all requested output ports. Each output port may grant in a different cycle.
- Pops the flit from the input FIFO only once every requested port has taken it. Also provides stall detection and packet/fork statistics.

---
 rtl/multicast_fork_scheduler.sv | 108 ++++++++++
 tb/tb_multicast_fork_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicast_fork_scheduler.sv
// Multicast fork scheduler: replicates each flit of a wormhole packet to every
// requested output port and pops the input FIFO once all of them have taken it.
module multicast_fork_scheduler #(
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_head,
  input  logic                 in_tail,
  input  logic [4:0]           in_routing,
  output logic                 in_pop,
  output logic [4:0]           out_req,
  input  logic [4:0]           out_gnt,
  output logic                 busy,
  output logic                 stall_alarm,
  output logic                 proto_err,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] fork_cnt
);

  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t         state;
  logic [4:0]     route_mask;
  logic [4:0]     pending;
  logic           first_flit;
  logic [SW-1:0]  stall_cnt;
  logic [4:0]     served;
  logic [4:0]     pending_next;
  logic           multi_port;

  assign out_req      = (state == FORWARD && in_valid) ? pending : 5'd0;
  assign served       = out_req & out_gnt;
  assign pending_next = pending & ~served;
  assign multi_port   = (route_mask & (route_mask - 5'd1)) != 5'd0;
  assign busy         = (state == FORWARD);
  assign stall_alarm  = (stall_cnt == SW'(STALL_LIMIT));

  // In IDLE only malformed flits are popped; a good head waits for FORWARD.
  always_comb begin
    in_pop = 1'b0;
    if (rst) begin
      if (state == IDLE)
        in_pop = in_valid & (~in_head | (in_routing == 5'd0));
      else
        in_pop = in_valid & (pending_next == 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      route_mask <= 5'd0;
      pending    <= 5'd0;
      first_flit <= 1'b0;
      stall_cnt  <= '0;
      proto_err  <= 1'b0;
      pkt_cnt    <= '0;
      fork_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_head && in_routing != 5'd0) begin
              route_mask <= in_routing;
              pending    <= in_routing;
              first_flit <= 1'b1;
              state      <= FORWARD;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        FORWARD: begin
          // A second head inside a packet is flagged but still forwarded.
          if (in_valid && in_head && !first_flit)
            proto_err <= 1'b1;
          if (served != 5'd0)
            stall_cnt <= '0;
          else if (out_req != 5'd0 && stall_cnt < SW'(STALL_LIMIT))
            stall_cnt <= stall_cnt + SW'(1);
          if (in_pop) begin
            first_flit <= 1'b0;
            if (in_tail) begin
              state      <= IDLE;
              route_mask <= 5'd0;
              pending    <= 5'd0;
              stall_cnt  <= '0;
              pkt_cnt    <= pkt_cnt + CNT_WIDTH'(1);
              if (multi_port)
                fork_cnt <= fork_cnt + CNT_WIDTH'(1);
            end else begin
              pending <= route_mask;
            end
          end else begin
            pending <= pending_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicast_fork_scheduler.sv
// Randomized bench for multicast_fork_scheduler against a packet-level model
// that tracks which ports have taken the current flit.
module tb_multicast_fork_scheduler;

  localparam int LIMIT = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_head, in_tail;
  logic [4:0]    in_routing, out_gnt;
  logic          in_pop, busy, stall_alarm, proto_err;
  logic [4:0]    out_req;
  logic [CW-1:0] pkt_cnt, fork_cnt;

  multicast_fork_scheduler #(.STALL_LIMIT(LIMIT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_routing(in_routing), .in_pop(in_pop),
    .out_req(out_req), .out_gnt(out_gnt), .busy(busy),
    .stall_alarm(stall_alarm), .proto_err(proto_err),
    .pkt_cnt(pkt_cnt), .fork_cnt(fork_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       head;
    logic       tail;
    logic [4:0] routing;
  } flit_t;

  flit_t fifo[$];

  int checks = 0;
  int errors = 0;

  // Reference model: packet in flight, its port set, ports that took this flit
  bit       mBusy, mFirst, mPerr;
  bit [4:0] mMask, mTaken;
  int       mPkt, mFork, mStall;
  bit [4:0] expReq;
  bit       expPop;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mFirst = 0; mPerr = 0; mMask = 0; mTaken = 0;
    mPkt = 0; mFork = 0; mStall = 0;
  endtask

  // Build one packet (sometimes malformed) into the FIFO model.
  task automatic genPacket();
    int r, len, k;
    flit_t f;
    r = $urandom_range(0, 99);
    if (r < 80) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        f.head = (i == 0); f.tail = (i == len - 1);
        f.routing = (i == 0) ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
        fifo.push_back(f);
      end
    end else if (r < 88) begin
      len = $urandom_range(1, 2);
      for (int i = 0; i < len; i++) begin
        f.head = (i == 0); f.tail = (i == len - 1); f.routing = 5'd0;
        fifo.push_back(f);
      end
    end else if (r < 94) begin
      f.head = 0; f.tail = 1'($urandom_range(0, 1)); f.routing = 5'($urandom_range(0, 31));
      fifo.push_back(f);
    end else begin
      len = $urandom_range(2, 4);
      k = $urandom_range(1, len - 1);
      for (int i = 0; i < len; i++) begin
        f.head = (i == 0) || (i == k); f.tail = (i == len - 1);
        f.routing = (i == 0) ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
        fifo.push_back(f);
      end
    end
  endtask

  task automatic computeExpected();
    bit [4:0] srv;
    expReq = (mBusy && in_valid) ? (mMask & ~mTaken) : 5'd0;
    srv = expReq & out_gnt;
    if (!mBusy)
      expPop = in_valid && (!in_head || in_routing == 5'd0);
    else
      expPop = in_valid && (((mTaken | srv) & mMask) == mMask);
  endtask

  task automatic applyStimulus(input int cyc);
    int mode;
    if (fifo.size() == 0) genPacket();
    in_valid   = ($urandom_range(0, 99) < 85);
    in_head    = fifo[0].head;
    in_tail    = fifo[0].tail;
    in_routing = fifo[0].routing;
    mode = (cyc / 250) % 4;
    case (mode)
      0: for (int b = 0; b < 5; b++) out_gnt[b] = ($urandom_range(0, 99) < 70);
      1: out_gnt = 5'h1f;
      2: for (int b = 0; b < 5; b++) out_gnt[b] = ($urandom_range(0, 99) < 20);
      default: out_gnt = (cyc % 25 == 0) ? 5'h1f : 5'd0;
    endcase
  endtask

  task automatic modelUpdate();
    bit [4:0] srv;
    srv = expReq & out_gnt;
    if (!mBusy) begin
      if (in_valid) begin
        if (in_head && in_routing != 5'd0) begin
          mBusy = 1; mMask = in_routing; mTaken = 0; mFirst = 1;
        end else mPerr = 1;
      end
    end else begin
      if (in_valid && in_head && !mFirst) mPerr = 1;
      if (srv != 0) mStall = 0;
      else if (expReq != 0 && mStall < LIMIT) mStall++;
      if (expPop) begin
        mFirst = 0; mTaken = 0;
        if (in_tail) begin
          mBusy = 0; mPkt++;
          if ($countones(mMask) > 1) mFork++;
          mMask = 0; mStall = 0;
        end
      end else mTaken |= srv;
    end
    if (expPop) void'(fifo.pop_front());
  endtask

  initial begin
    bit resetWanted;
    rst = 1'b0; in_valid = 0; in_head = 0; in_tail = 0; in_routing = 0; out_gnt = 0;
    modelReset();
    resetWanted = 0;
    #1;
    checkOutput("reset_out_req", 32'(out_req), 0);
    checkOutput("reset_in_pop", 32'(in_pop), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_pkt_cnt", 32'(pkt_cnt), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      applyStimulus(cyc);
      #1;
      computeExpected();
      checkOutput("out_req", 32'(out_req), 32'(expReq));
      checkOutput("in_pop", 32'(in_pop), 32'(expPop));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("stall_alarm", 32'(stall_alarm), 32'(mStall == LIMIT));
      checkOutput("proto_err", 32'(proto_err), 32'(mPerr));
      checkOutput("pkt_cnt", 32'(pkt_cnt), 32'(mPkt % (1 << CW)));
      checkOutput("fork_cnt", 32'(fork_cnt), 32'(mFork % (1 << CW)));
      @(posedge clk);
      modelUpdate();
      if (cyc % 900 == 450) resetWanted = 1;
      if (resetWanted && mBusy) begin
        resetWanted = 0;
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_out_req", 32'(out_req), 0);
        checkOutput("async_rst_in_pop", 32'(in_pop), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_pkt_cnt", 32'(pkt_cnt), 0);
        checkOutput("async_rst_fork_cnt", 32'(fork_cnt), 0);
        checkOutput("async_rst_proto_err", 32'(proto_err), 0);
        modelReset();
        fifo.delete();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
